fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_arb_pkg.sv | 14 +
 rtl/rr_pick.sv | 36 +++
 rtl/fifo_wr_arbiter.sv | 107 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter: FSM state encoding
// and default parameter values used by the arbiter and its instantiators.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int DATAWIDTH_DEF = 8;
  localparam int NREQ_DEF      = 4;
  localparam int MAXBURST_DEF  = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first asserted request at
// or above ptr, wrapping past the top index back to 0.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N  = NREQ_DEF,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] gnt_idx,
  output logic          any_req
);

  // Scan offsets from the far end down so the nearest hit to ptr wins last.
  always_comb begin
    logic [IW:0]   sum;
    logic [IW-1:0] idx;
    gnt_idx = '0;
    any_req = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int off = N - 1; off >= 0; off--) begin
      sum = {1'b0, ptr} + (IW + 1)'(off);
      if (sum >= (IW + 1)'(N)) begin
        sum = sum - (IW + 1)'(N);
      end
      idx = sum[IW-1:0];
      if (req[idx]) begin
        gnt_idx = idx;
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Arbitrates several packet sources onto a single FIFO write port.
// A requester is granted round-robin from IDLE and keeps the port until it
// sends its last word or has written maxburst words; every grant is
// followed by one IDLE cycle before the next arbitration.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int datawidth = DATAWIDTH_DEF,
  parameter int nreq      = NREQ_DEF,
  parameter int maxburst  = MAXBURST_DEF
) (
  input  logic                      wclk,
  input  logic                      wrst_n,
  input  logic [nreq-1:0]           req_valid,
  input  logic [nreq*datawidth-1:0] req_data,
  input  logic [nreq-1:0]           req_last,
  output logic [nreq-1:0]           req_ready,
  input  logic                      wfull,
  output logic                      winc,
  output logic [datawidth-1:0]      wdata,
  output logic [$clog2(nreq)-1:0]   gnt_id,
  output logic                      busy
);

  localparam int IW = $clog2(nreq);
  localparam int BW = $clog2(maxburst + 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(nreq - 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(maxburst);

  arb_state_t    state_reg, state_next;
  logic [IW-1:0] gnt_reg, gnt_next;
  logic [IW-1:0] rr_ptr_reg, rr_ptr_next;
  logic [BW-1:0] burst_cnt_reg, burst_cnt_next;
  logic [BW-1:0] burst_cnt_inc;
  logic [IW-1:0] pick_idx;
  logic          any_req;

  logic [datawidth-1:0] data_slice [nreq];

  rr_pick #(
    .N  (nreq),
    .IW (IW)
  ) u_rr_pick (
    .req     (req_valid),
    .ptr     (rr_ptr_reg),
    .gnt_idx (pick_idx),
    .any_req (any_req)
  );

  // Per-requester views of the flat data bus and ready strobes.
  generate
    for (genvar gi = 0; gi < nreq; gi++) begin : g_req
      assign data_slice[gi] = req_data[gi*datawidth +: datawidth];
      assign req_ready[gi]  = busy & (gnt_reg == IW'(gi)) & ~wfull;
    end
  endgenerate

  assign busy   = (state_reg == BUSY);
  assign winc   = busy & req_valid[gnt_reg] & ~wfull;
  assign wdata  = data_slice[gnt_reg];
  assign gnt_id = gnt_reg;

  // State, grant, round-robin pointer and burst counter registers.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_reg     <= IDLE;
      gnt_reg       <= '0;
      rr_ptr_reg    <= '0;
      burst_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      gnt_reg       <= gnt_next;
      rr_ptr_reg    <= rr_ptr_next;
      burst_cnt_reg <= burst_cnt_next;
    end
  end

  // Next-state: grant from IDLE, count transfers in BUSY, release on last or
  // when the burst limit is reached (a coincident last and limit is one release).
  always_comb begin
    state_next     = state_reg;
    gnt_next       = gnt_reg;
    rr_ptr_next    = rr_ptr_reg;
    burst_cnt_next = burst_cnt_reg;
    burst_cnt_inc  = burst_cnt_reg + BW'(1);
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          gnt_next       = pick_idx;
          burst_cnt_next = '0;
          state_next     = BUSY;
        end
      end
      BUSY: begin
        if (winc) begin
          burst_cnt_next = burst_cnt_inc;
          if (req_last[gnt_reg] || (burst_cnt_inc == BURST_MAX)) begin
            state_next  = IDLE;
            rr_ptr_next = (gnt_reg == LAST_IDX) ? '0 : gnt_reg + IW'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter: packet sources with random lengths
// and gaps, random FIFO-full back-pressure, and a mid-packet reset, all
// checked cycle by cycle against a behavioural model of the arbitration rules.
module tb_fifo_wr_arbiter;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int MB = 16;

  logic             wclk = 1'b0;
  logic             wrst_n;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_last;
  logic [NR-1:0]    req_ready;
  logic             wfull;
  logic             winc;
  logic [DW-1:0]    wdata;
  logic [1:0]       gnt_id;
  logic             busy;

  fifo_wr_arbiter #(
    .datawidth (DW),
    .nreq      (NR),
    .maxburst  (MB)
  ) dut (
    .wclk      (wclk),
    .wrst_n    (wrst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .wfull     (wfull),
    .winc      (winc),
    .wdata     (wdata),
    .gnt_id    (gnt_id),
    .busy      (busy)
  );

  always #5 wclk = ~wclk;

  int n_checks = 0;
  int n_pass   = 0;

  // Packet sources.
  bit src_active [NR];
  int src_len    [NR];
  int src_idx    [NR];
  int src_seq    [NR];
  int len_tbl    [7] = '{1, 3, 4, 16, 20, 2, 17};
  int full_run;

  // Reference model of the port owner.
  bit m_busy;
  int m_owner;
  int m_cnt;
  int m_ptr;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic [7:0] word_of(input int r);
    return 8'(r * 64 + (src_seq[r] % 64));
  endfunction

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_cnt   = 0;
    m_ptr   = 0;
    for (int i = 0; i < NR; i++) begin
      src_active[i] = 1'b0;
      src_idx[i]    = 0;
      src_len[i]    = 1;
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < NR; i++) begin
      if (!src_active[i] && $urandom_range(0, 3) == 0) begin
        src_active[i] = 1'b1;
        src_len[i]    = len_tbl[$urandom_range(0, 6)];
        src_idx[i]    = 0;
      end
      req_valid[i] = src_active[i] && ($urandom_range(0, 9) != 0);
      req_last[i]  = src_active[i] ? (src_idx[i] == src_len[i] - 1) : 1'($urandom_range(0, 1));
      req_data[i*DW +: DW] = word_of(i);
    end
    if (full_run > 0) begin
      wfull = 1'b1;
      full_run--;
    end else if ($urandom_range(0, 39) == 0) begin
      wfull    = 1'b1;
      full_run = 4;
    end else begin
      wfull = ($urandom_range(0, 7) == 0);
    end
  endtask

  // One clock cycle: drive, check combinational outputs, advance the model.
  task automatic step();
    logic [NR-1:0] exp_ready;
    logic          exp_winc;
    bit            found;
    bit            lst;
    int            cand;
    drive_inputs();
    #1;
    exp_ready = '0;
    exp_winc  = 1'b0;
    if (m_busy) begin
      exp_ready[m_owner] = !wfull;
      exp_winc           = req_valid[m_owner] && !wfull;
    end
    check_eq("busy", 32'(busy), 32'(m_busy));
    check_eq("gnt_id", 32'(gnt_id), 32'(m_owner));
    check_eq("req_ready", 32'(req_ready), 32'(exp_ready));
    check_eq("winc", 32'(winc), 32'(exp_winc));
    if (exp_winc) check_eq("wdata", 32'(wdata), 32'(word_of(m_owner)));
    @(posedge wclk);
    if (!m_busy) begin
      found = 1'b0;
      for (int k = 0; k < NR; k++) begin
        cand = (m_ptr + k) % NR;
        if (!found && req_valid[cand]) begin
          found   = 1'b1;
          m_owner = cand;
        end
      end
      if (found) begin
        m_busy = 1'b1;
        m_cnt  = 0;
      end
    end else if (exp_winc) begin
      m_cnt++;
      lst = req_last[m_owner];
      src_idx[m_owner]++;
      src_seq[m_owner]++;
      if (src_idx[m_owner] == src_len[m_owner]) src_active[m_owner] = 1'b0;
      if (lst || m_cnt == MB) begin
        $display("grant rq=%0d words=%0d end=%s", m_owner, m_cnt, lst ? "last" : "maxburst");
        m_busy = 1'b0;
        m_ptr  = (m_owner + 1) % NR;
      end
    end
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_winc"}, 32'(winc), 32'd0);
    check_eq({tag, "_ready"}, 32'(req_ready), 32'd0);
    check_eq({tag, "_gnt"}, 32'(gnt_id), 32'd0);
  endtask

  // Wait for a packet in flight, then pulse reset asynchronously.
  task automatic mid_reset();
    int guard = 0;
    while (!(m_busy && m_cnt >= 1) && guard < 500) begin
      step();
      guard++;
    end
    check_eq("midpkt_reached", 32'(guard < 500), 32'd1);
    $display("reset pulse while rq=%0d owns port after %0d words", m_owner, m_cnt);
    #1;
    wrst_n = 1'b0;
    #1;
    check_outputs_zero("async_rst");
    model_reset();
    repeat (2) @(posedge wclk);
    #1;
    check_outputs_zero("in_rst");
    wrst_n = 1'b1;
  endtask

  initial begin
    wrst_n    = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    wfull     = 1'b0;
    full_run  = 0;
    for (int i = 0; i < NR; i++) src_seq[i] = 0;
    model_reset();
    #1;
    check_outputs_zero("por");
    repeat (2) @(posedge wclk);
    #1;
    wrst_n = 1'b1;
    repeat (1500) step();
    mid_reset();
    repeat (1500) step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
